// File: rtl/dbg_frame_pkg.sv
// dbg_frame_pkg: shared types and constants for the debug frame parser
package dbg_frame_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WDATA, S_WR, S_RD_REQ, S_RD_WAIT, S_TX} state_t;
  localparam logic [7:0] CMD_READ = 8'h01;
  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] ESC_CODE_DEFAULT = 8'hB1;
  localparam int RESP_LEN = 4;
endpackage

// File: rtl/dbg_frame_parser.sv
// dbg_frame_parser: escape-delimited UART command frames into debug register reads/writes
module dbg_frame_parser
  import dbg_frame_pkg::*;
#(
  parameter logic [7:0] ESC_CODE = ESC_CODE_DEFAULT,
  parameter int RD_TIMEOUT = 255
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        RX_EMPTY_I,
  input  logic [7:0]  DREC_I,
  output logic        RE_O,
  input  logic        TX_READY_I,
  output logic        WE_O,
  output logic [7:0]  DSEND_O,
  output logic        ESC_DETECTED_O,
  output logic [7:0]  REG_ADDR_O,
  output logic        REG_WE_O,
  output logic [31:0] REG_WDATA_O,
  output logic        REG_RE_O,
  input  logic [31:0] REG_RDATA_I,
  input  logic        REG_RVALID_I,
  output logic        ERR_O
);
  localparam int TW = $clog2(RD_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(RD_TIMEOUT);
  localparam logic [1:0] LAST_BYTE = 2'(RESP_LEN - 1);
  state_t state_q, state_d;
  logic esc_pend_q, esc_pend_d, is_write_q, is_write_d, err_q, err_d, we_prev_q;
  logic [1:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic rx_state, in_body, pop, is_esc, cmd_ok, take_cmd, data_ok, we, timed_out;
  assign rx_state = state_q inside {S_IDLE, S_CMD, S_ADDR, S_WDATA};
  assign in_body = state_q inside {S_ADDR, S_WDATA};
  assign pop = rx_state && !RX_EMPTY_I && !RST_I;
  assign is_esc = DREC_I == ESC_CODE;
  assign cmd_ok = DREC_I == CMD_READ || DREC_I == CMD_WRITE;
  // a non-ESC byte after a pending ESC aborts the frame and is reused as the next CMD
  assign take_cmd = pop && !is_esc && (state_q == S_CMD || (in_body && esc_pend_q));
  assign data_ok = pop && in_body && (esc_pend_q == is_esc);
  assign we = state_q == S_TX && TX_READY_I && !we_prev_q;
  assign timed_out = state_q == S_RD_WAIT && !REG_RVALID_I && tmo_q == TMO_MAX;
  always_ff @(posedge CLK_I) begin
    if (RST_I) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (take_cmd) state_d = cmd_ok ? S_ADDR : S_IDLE;
    else case (state_q)
      S_IDLE:    state_d = (pop && is_esc) ? S_CMD : S_IDLE;
      S_ADDR:    if (data_ok) state_d = is_write_q ? S_WDATA : S_RD_REQ;
      S_WDATA:   if (data_ok && cnt_q == 2'd3) state_d = S_WR;
      S_WR:      state_d = S_IDLE;
      S_RD_REQ:  state_d = S_RD_WAIT;
      S_RD_WAIT: state_d = REG_RVALID_I ? S_TX : timed_out ? S_IDLE : S_RD_WAIT;
      S_TX:      if (we && cnt_q == LAST_BYTE) state_d = S_IDLE;
      default:   state_d = state_q;
    endcase
  end
  always_comb begin
    esc_pend_d = in_body && (pop ? is_esc && !esc_pend_q : esc_pend_q);
    is_write_d = (take_cmd && cmd_ok) ? DREC_I == CMD_WRITE : is_write_q;
    err_d = err_q || (take_cmd && !cmd_ok) || timed_out;
    addr_d = (state_q == S_ADDR && data_ok) ? DREC_I : addr_q;
    cnt_d = cnt_q;
    if ((state_q == S_ADDR && data_ok) || (state_q == S_RD_WAIT && REG_RVALID_I)) cnt_d = 2'd0;
    else if ((state_q == S_WDATA && data_ok) || we) cnt_d = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
    wdata_d = wdata_q;
    if (state_q == S_WDATA && data_ok) wdata_d[8*cnt_q +: 8] = DREC_I;
    tmo_d = (state_q == S_RD_REQ) ? '0 : (state_q == S_RD_WAIT && tmo_q != TMO_MAX) ? tmo_q + TW'(1) : tmo_q;
    rdata_d = (state_q == S_RD_WAIT && REG_RVALID_I) ? REG_RDATA_I : rdata_q;
  end
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      esc_pend_q <= 1'b0;
      is_write_q <= 1'b0;
      err_q <= 1'b0;
      we_prev_q <= 1'b0;
      cnt_q <= '0;
      tmo_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      esc_pend_q <= esc_pend_d;
      is_write_q <= is_write_d;
      err_q <= err_d;
      we_prev_q <= we;
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  always_comb begin
    RE_O = pop;
    WE_O = we;
    DSEND_O = we ? rdata_q[8*cnt_q +: 8] : 8'h00;
    ESC_DETECTED_O = state_q inside {S_CMD, S_ADDR, S_WDATA} || (state_q == S_IDLE && esc_pend_q);
    REG_WE_O = state_q == S_WR;
    REG_RE_O = state_q == S_RD_REQ;
    REG_ADDR_O = addr_q;
    REG_WDATA_O = wdata_q;
    ERR_O = err_q;
  end
endmodule

// File: tb/tb_dbg_frame_parser.sv
// tb_dbg_frame_parser: directed self-checking bench for the debug frame parser
module tb_dbg_frame_parser;
  logic clk = 1'b0;
  logic rst, rx_empty, re, tx_ready, we, esc_det, reg_we, reg_re, rvalid, err;
  logic [7:0] drec, dsend, reg_addr;
  logic [31:0] reg_wdata, rdata;
  logic [7:0] mem [0:255];
  int head = 0, tail = 0;
  logic hold = 1'b0;
  int checks = 0, failures = 0;
  int wr_n = 0, rd_n = 0, tx_n = 0, tx_bad = 0;
  logic [7:0] wr_addr_s, rd_addr_s;
  logic [31:0] wr_data_s, rexp;
  logic [7:0] tx_buf [0:63];
  logic we_prev = 1'b0;
  int b, b2, t, n;

  dbg_frame_parser dut (
    .CLK_I(clk), .RST_I(rst), .RX_EMPTY_I(rx_empty), .DREC_I(drec), .RE_O(re),
    .TX_READY_I(tx_ready), .WE_O(we), .DSEND_O(dsend), .ESC_DETECTED_O(esc_det),
    .REG_ADDR_O(reg_addr), .REG_WE_O(reg_we), .REG_WDATA_O(reg_wdata), .REG_RE_O(reg_re),
    .REG_RDATA_I(rdata), .REG_RVALID_I(rvalid), .ERR_O(err)
  );

  always #5 clk = ~clk;

  assign rx_empty = hold || head == tail;
  assign drec = mem[head[7:0]];
  always @(posedge clk) if (re) head <= head + 1;

  always @(negedge clk) begin
    if (reg_we === 1'b1) begin wr_n++; wr_addr_s = reg_addr; wr_data_s = reg_wdata; end
    if (reg_re === 1'b1) begin rd_n++; rd_addr_s = reg_addr; end
    if (we === 1'b1) begin
      tx_buf[tx_n] = dsend;
      tx_n++;
      if (!tx_ready || we_prev) tx_bad++;
    end
    we_prev = (we === 1'b1);
  end

  task automatic tick(input int k = 1);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [7:0] v);
    mem[tail] = v;
    tail++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1; tx_ready = 1; rvalid = 0; rdata = 0;
    tick(2);
    check("reset_outs", {re, we, dsend, esc_det, reg_addr, reg_we, reg_re, err}, 0);
    check("reset_wdata", reg_wdata, 0);
    rst = 0; tick();
    // plain write
    b = wr_n;
    push(8'hB1); push(8'h02); push(8'h10); push(8'hEF); push(8'hBE); push(8'hAD); push(8'hDE);
    tick(6); check("wr_before_last", reg_we, 0);
    tick(); check("wr_strobe", reg_we, 1); check("wr_addr", reg_addr, 8'h10); check("wr_data", reg_wdata, 32'hDEADBEEF);
    tick(); check("wr_one_cycle", reg_we, 0);
    tick(3); check("wr_count", wr_n - b, 1); check("wr_err", err, 0);
    // read with TX back-pressure
    b = rd_n; t = tx_n;
    push(8'hB1); push(8'h01); push(8'h20);
    tick(3); check("rd_strobe", reg_re, 1); check("rd_addr", reg_addr, 8'h20);
    tick(3); check("rd_no_early_tx", we, 0);
    rvalid = 1; rdata = 32'h12345678; tick(); rvalid = 0; rdata = 0;
    for (int i = 0; i < 30; i++) begin tx_ready = (i % 3) != 1; tick(); end
    tx_ready = 1;
    check("rd_tx_count", tx_n - t, 4);
    rexp = 32'h12345678;
    for (int i = 0; i < 4; i++) check("rd_tx_byte", tx_buf[t+i], rexp[8*i +: 8]);
    check("rd_tx_guard", tx_bad, 0); check("rd_count", rd_n - b, 1); check("rd_err", err, 0);
    t = tx_n;
    rvalid = 1; rdata = 32'hAABBCCDD; tick(); rvalid = 0; tick(5);
    check("rvalid_ignored", tx_n - t, 0);
    // escaped literal ESC in data
    b = wr_n;
    push(8'hB1); push(8'h02); push(8'h05); push(8'hB1); push(8'hB1); push(8'h00); push(8'h00); push(8'h00);
    tick(12);
    check("esc_wr_count", wr_n - b, 1); check("esc_wr_addr", wr_addr_s, 8'h05); check("esc_wr_data", wr_data_s, 32'h000000B1);
    // leading garbage before a read
    b = rd_n; t = tx_n;
    push(8'h55); push(8'hAA); push(8'hB1); push(8'h01); push(8'h07);
    tick(5); check("garb_rd_strobe", reg_re, 1); check("garb_rd_addr", reg_addr, 8'h07);
    tick(); rvalid = 1; rdata = 32'hCAFEF00D; tick(); rvalid = 0; rdata = 0;
    tick(12);
    check("garb_tx_count", tx_n - t, 4); check("garb_tx_b0", tx_buf[t], 8'h0D); check("garb_tx_b3", tx_buf[t+3], 8'hCA);
    check("garb_rd_count", rd_n - b, 1);
    // empty FIFO stalls
    b = rd_n; t = tx_n;
    hold = 1;
    push(8'hB1); push(8'h01); push(8'h30);
    tick(3); check("stall_idle", {re, esc_det}, 0);
    hold = 0; tick(); hold = 1; #1;
    check("stall_cmd_esc", esc_det, 1); check("stall_re", re, 0);
    tick(3); check("stall_held", {esc_det, reg_re}, 2'b10);
    hold = 0; tick(2);
    check("stall_rd_strobe", reg_re, 1); check("stall_rd_addr", reg_addr, 8'h30);
    tick(); rvalid = 1; tick(); rvalid = 0; tick(10);
    check("stall_tx_count", tx_n - t, 4);
    // mid-frame abort into a read that times out
    b = rd_n; b2 = wr_n; t = tx_n;
    push(8'hB1); push(8'h02); push(8'h05); push(8'h11); push(8'hB1); push(8'h01); push(8'h09);
    tick(7); check("abort_rd_strobe", reg_re, 1); check("abort_rd_addr", reg_addr, 8'h09);
    n = 0;
    while (!err && n < 300) begin tick(); n++; end
    check("tmo_cycles", n, 257); check("tmo_err", err, 1);
    check("abort_no_wr", wr_n - b2, 0); check("tmo_no_tx", tx_n - t, 0); check("abort_rd_count", rd_n - b, 1);
    check("tmo_idle", esc_det, 0);
    // reset mid-frame
    push(8'hB1); push(8'h02); push(8'h10); push(8'hAA);
    tick(4); check("rst_mid_frame", esc_det, 1);
    push(8'h55); rst = 1; #1;
    check("rst_no_pop", re, 0);
    tick();
    check("rst_outs", {re, we, dsend, esc_det, reg_addr, reg_we, reg_re, err}, 0);
    check("rst_wdata", reg_wdata, 0);
    rst = 0; tick(3);
    b = wr_n;
    push(8'hB1); push(8'h02); push(8'h33); push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    tick(12);
    check("post_rst_wr_count", wr_n - b, 1); check("post_rst_wr_addr", wr_addr_s, 8'h33);
    check("post_rst_wr_data", wr_data_s, 32'h04030201); check("post_rst_err", err, 0);
    // unknown command
    b = wr_n; b2 = rd_n;
    push(8'hB1); push(8'h7F);
    tick(2); check("badcmd_err", err, 1); check("badcmd_idle", esc_det, 0);
    tick(3); check("badcmd_no_req", (wr_n - b) + (rd_n - b2), 0);
    check("badcmd_sticky", err, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
